instruction_fetcher: RTL and testbench
======================================

// Module: instruction_fetcher
// PURPOSE
//  Front end of the core; sole producer for the instruction queue. Holds the fetch PC and
//  reads 32-bit words through a small direct-mapped icache. Misses are refilled over a
//  req/valid memory port. Applies static branch prediction, then pushes {instr, pc,
//  predict} into the queue. Redirects to rollback_pc on roll_back.
// PARAMETERS
//  RESET_PC        32'h0  fetch PC after reset
//  ICACHE_ENTRIES  32     direct-mapped word entries, power of two; IDX=log2(ICACHE_ENTRIES)
// PORTS
//  clk_in             in   1   system clock, single clock domain
//  rst_in             in   1   reset, asynchronous, active-low
//  rdy_in             in   1   global ready; low = pause
//  roll_back          in   1   mispredict flush; redirect fetch
//  rollback_pc        in   32  correct PC; valid when roll_back=1
//  isq_is_full        in   1   instruction queue full; no push allowed this cycle
//  instruction_ready  out  1   push strobe to queue (combinational)
//  instruction_out    out  32  instruction word
//  pc_out             out  32  PC of instruction_out
//  pc_predict_out     out  1   1 = predicted taken
//  mem_req            out  1   refill request; held until mem_valid
//  mem_addr           out  32  refill word address; {pc[31:2],2'b00}
//  mem_valid          in   1   one-cycle pulse; mem_data valid
//  mem_data           in   32  refill word
// BEHAVIOUR
//  - Reset (rst_in=0, async): pc=RESET_PC, state=LOOKUP, mem_req=0, mem_addr=0,
//    all icache valid bits=0. instruction_ready is 0 because every lookup misses.
//  - icache: index=pc[IDX+1:2], tag=pc[31:IDX+2], plus one valid bit per entry.
//    Read is combinational. hit = valid[idx] && tag match. roll_back never invalidates entries.
//  - Outputs: instruction_ready = (state==LOOKUP) && hit && !isq_is_full && !roll_back && rdy_in.
//    instruction_out = cached word. pc_out = pc. The queue captures on the same edge.
//    Throughput is 1 instr/cycle on hits.
//  - Prediction, on the pushed word w:
//    - opcode 1101111 (JAL): predict=1, next=pc+Jimm.
//      Jimm = {{12{w[31]}},w[19:12],w[20],w[30:21],1'b0}.
//    - opcode 1100011 (B): predict=w[31] (backward taken), next = w[31] ? pc+Bimm : pc+4.
//      Bimm = {{20{w[31]}},w[7],w[30:25],w[11:8],1'b0}.
//    - All others, JALR included: predict=0, next=pc+4.
//    - All adds are 32-bit modulo 2^32.
//  - FSM (all transitions gated by rdy_in=1):
//    - LOOKUP:
//      - roll_back: pc<=rollback_pc, stay in LOOKUP.
//      - Hit and push: pc<=next.
//      - Hit and isq_is_full: hold.
//      - Miss: mem_req<=1, mem_addr<={pc[31:2],00}, go to MISS.
//    - MISS:
//      - mem_valid: write entry (data, tag, valid=1), mem_req<=0, go to LOOKUP (hits next cycle).
//      - roll_back without mem_valid: pc<=rollback_pc, go to ABORT.
//      - roll_back with mem_valid: fill the entry, pc<=rollback_pc, go to LOOKUP.
//    - ABORT:
//      - mem_req stays high with the old mem_addr.
//      - mem_valid: fill the entry (data is correct for the old addr), mem_req<=0, go to LOOKUP.
//      - roll_back: pc<=rollback_pc, stay in ABORT.
//  - mem handshake: mem_req/mem_addr stay stable from assertion until the mem_valid cycle.
//    At most one outstanding request.
//  - rdy_in=0: every register holds and instruction_ready=0. The memory side never pulses
//    mem_valid while rdy_in=0.
//  - roll_back has priority over hit, push and miss start in the same cycle.
//    No instruction is pushed in a roll_back cycle.
//  - rst_in mid-miss: FSM drops to LOOKUP and mem_req drops immediately.
//    A late mem_valid in LOOKUP is ignored.
// TESTING
//  - Cold start, RESET_PC=0, mem returns 32'h00000013 x4:
//    -> 4 misses, mem_addr 0,4,8,C; pushes pc_out 0,4,8,C; predict=0 for each.
//  - Warm loop, word at 0x10 = BEQ with Bimm=-16 (w[31]=1), all lines cached:
//    -> push 0x10 with predict=1, then the next push is pc_out=0x0; 1 push/cycle.
//  - JAL at 0x0 with Jimm=+0x100 -> predict=1, next pc_out=0x100.
//  - isq_is_full held 3 cycles on a hit:
//    -> instruction_ready=0 for 3 cycles, pc unchanged; one push after release, no duplicates.
//  - roll_back (rollback_pc=0x40) 2 cycles after miss start, mem_valid at cycle 5:
//    -> mem_req held to cycle 5, old line filled, first push pc_out=0x40;
//       no push of the stale address.
//  - rdy_in=0 for 4 cycles during MISS with mem_valid withheld:
//    -> all outputs frozen; on resume, the fill completes and fetch continues unchanged.

Source files
------------

// File: rtl/instruction_fetcher_if.sv
// Queue push and memory refill signals shared between the fetcher and its environment.
// The master side is the fetcher; the slave side is the queue and memory.
interface instruction_fetcher_if;
    logic        isq_is_full;
    logic        instruction_ready;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic        pc_predict_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    modport master (
        input  isq_is_full, mem_valid, mem_data,
        output instruction_ready, instruction_out, pc_out, pc_predict_out, mem_req, mem_addr
    );

    modport slave (
        output isq_is_full, mem_valid, mem_data,
        input  instruction_ready, instruction_out, pc_out, pc_predict_out, mem_req, mem_addr
    );
endinterface

// File: rtl/instruction_fetcher.sv
// Fetch front end: PC register, direct-mapped word icache with single-request refill,
// static branch prediction and push into the instruction queue.
module instruction_fetcher #(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          ICACHE_ENTRIES = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  roll_back,
    input  logic [31:0]           rollback_pc,
    instruction_fetcher_if.master bus
);
    localparam int IDX   = $clog2(ICACHE_ENTRIES);
    localparam int TAG_W = 30 - IDX;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {LOOKUP = 2'd0, MISS = 2'd1, ABORT = 2'd2} state_t;

    state_t              state_r, state_nxt_s;
    logic [31:0]         pc_r, pc_nxt_s;
    logic                mem_req_r, mem_req_nxt_s;
    logic [31:0]         mem_addr_r, mem_addr_nxt_s;
    logic [ICACHE_ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]    tag_r  [ICACHE_ENTRIES];
    logic [31:0]         data_r [ICACHE_ENTRIES];

    logic [IDX-1:0]      idx_s, fill_idx_s;
    logic [TAG_W-1:0]    tag_s, fill_tag_s;
    logic                hit_s, push_s, fill_s, predict_s;
    logic [31:0]         word_s, next_pc_s;

    function automatic logic [31:0] j_imm(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] w);
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    // Fills always target the outstanding request address, which may differ from pc after a redirect.
    assign idx_s      = pc_r[IDX+1:2];
    assign tag_s      = pc_r[31:IDX+2];
    assign fill_idx_s = mem_addr_r[IDX+1:2];
    assign fill_tag_s = mem_addr_r[31:IDX+2];
    assign word_s     = data_r[idx_s];
    assign hit_s      = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    assign push_s     = (state_r == LOOKUP) && hit_s && !bus.isq_is_full && !roll_back && rdy_in;

    // Static prediction on the cached word at pc.
    always_comb begin
        predict_s = 1'b0;
        next_pc_s = pc_r + 32'd4;
        case (word_s[6:0])
            OP_JAL: begin
                predict_s = 1'b1;
                next_pc_s = pc_r + j_imm(word_s);
            end
            OP_BRANCH: begin
                predict_s = word_s[31];
                if (word_s[31]) begin
                    next_pc_s = pc_r + b_imm(word_s);
                end else begin
                    next_pc_s = pc_r + 32'd4;
                end
            end
            default: begin
                predict_s = 1'b0;
            end
        endcase
    end

    // Next-state logic; roll_back takes priority over hit, push and miss start.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        mem_req_nxt_s  = mem_req_r;
        mem_addr_nxt_s = mem_addr_r;
        fill_s         = 1'b0;
        if (rdy_in) begin
            case (state_r)
                LOOKUP: begin
                    if (roll_back) begin
                        pc_nxt_s = rollback_pc;
                    end else if (hit_s) begin
                        if (!bus.isq_is_full) begin
                            pc_nxt_s = next_pc_s;
                        end else begin
                            pc_nxt_s = pc_r;
                        end
                    end else begin
                        mem_req_nxt_s  = 1'b1;
                        mem_addr_nxt_s = {pc_r[31:2], 2'b00};
                        state_nxt_s    = MISS;
                    end
                end
                MISS, ABORT: begin
                    if (bus.mem_valid) begin
                        fill_s        = 1'b1;
                        mem_req_nxt_s = 1'b0;
                        state_nxt_s   = LOOKUP;
                        if (roll_back) begin
                            pc_nxt_s = rollback_pc;
                        end else begin
                            pc_nxt_s = pc_r;
                        end
                    end else if (roll_back) begin
                        pc_nxt_s    = rollback_pc;
                        state_nxt_s = ABORT;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s   = LOOKUP;
                    mem_req_nxt_s = 1'b0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Control registers and cache valid bits.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r    <= LOOKUP;
            pc_r       <= RESET_PC;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0;
            valid_r    <= '0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            mem_req_r  <= mem_req_nxt_s;
            mem_addr_r <= mem_addr_nxt_s;
            if (fill_s) begin
                valid_r[fill_idx_s] <= 1'b1;
            end
        end
    end

    // Cache data and tag storage, written only on a refill.
    always_ff @(posedge clk_in) begin
        if (fill_s) begin
            data_r[fill_idx_s] <= bus.mem_data;
            tag_r[fill_idx_s]  <= fill_tag_s;
        end
    end

    assign bus.instruction_ready = push_s;
    assign bus.instruction_out   = word_s;
    assign bus.pc_out            = pc_r;
    assign bus.pc_predict_out    = predict_s;
    assign bus.mem_req           = mem_req_r;
    assign bus.mem_addr          = mem_addr_r;
endmodule

// File: tb/tb_instruction_fetcher.sv
// Randomized and directed bench for instruction_fetcher against an instruction-stream reference model.
module tb_instruction_fetcher;
    logic        clk_in      = 1'b0;
    logic        rst_in      = 1'b0;
    logic        rdy_in      = 1'b0;
    logic        roll_back   = 1'b0;
    logic [31:0] rollback_pc = 32'h0;

    instruction_fetcher_if bus ();

    instruction_fetcher #(.RESET_PC(32'h0), .ICACHE_ENTRIES(32)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .roll_back  (roll_back),
        .rollback_pc(rollback_pc),
        .bus        (bus.master)
    );

    always #5 clk_in = ~clk_in;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] prog [256];
    logic [31:0] exp_pc = 32'h0;
    int          push_cnt = 0;
    int          cyc = 0;
    int          push_cyc_q [$];
    logic [31:0] push_pc_q [$];
    logic        push_pred_q [$];
    logic [31:0] miss_q [$];
    logic        prev_req = 1'b0;
    logic        prev_consumed = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        mon_pred;
    logic [31:0] mon_nxt;
    int          mem_lat = 0;
    int          lat_cnt = 0;
    bit          hold_mem = 1'b0;
    bit          rand_lat = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd1024) return prog[a[9:2]];
        return 32'h00000013;
    endfunction

    function automatic logic [31:0] enc_b(input int imm);
        logic [31:0] i;
        i = imm;
        return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [31:0] i;
        i = imm;
        return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
    endfunction

    // Reference: where fetch goes after word w at pc, and whether it is predicted taken.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w, output logic pred);
        int imm;
        pred = 1'b0;
        imm  = 4;
        if (w[6:0] == 7'b1101111) begin
            pred = 1'b1;
            imm  = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096 - (w[31] ? (1 << 20) : 0);
        end else if (w[6:0] == 7'b1100011 && w[31]) begin
            pred = 1'b1;
            imm  = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - 4096;
        end
        return pc + 32'(imm);
    endfunction

    // Monitor and scoreboard, sampling away from the active edge.
    always @(negedge clk_in) begin
        cyc++;
        if (!rst_in) begin
            exp_pc        = 32'h0;
            prev_req      = 1'b0;
            prev_consumed = 1'b0;
        end else begin
            check_val("push_gate", {31'd0, bus.instruction_ready & (roll_back | ~rdy_in | bus.isq_is_full)}, 32'd0);
            if (bus.instruction_ready) begin
                mon_nxt = ref_next(exp_pc, mem_word(exp_pc), mon_pred);
                check_val("pc_out", bus.pc_out, exp_pc);
                check_val("instr", bus.instruction_out, mem_word(exp_pc));
                check_val("predict", {31'd0, bus.pc_predict_out}, {31'd0, mon_pred});
                push_pc_q.push_back(bus.pc_out);
                push_pred_q.push_back(bus.pc_predict_out);
                push_cyc_q.push_back(cyc);
                push_cnt++;
                exp_pc = mon_nxt;
            end else if (roll_back && rdy_in) begin
                exp_pc = rollback_pc;
            end
            if (prev_req && !prev_consumed) begin
                check_val("req_hold", {31'd0, bus.mem_req}, 32'd1);
                check_val("addr_hold", bus.mem_addr, prev_addr);
            end
            if (bus.mem_req && !prev_req) miss_q.push_back(bus.mem_addr);
            prev_req      = bus.mem_req;
            prev_addr     = bus.mem_addr;
            prev_consumed = bus.mem_valid && rdy_in;
        end
    end

    // Memory responder: one pulse per request after mem_lat ready cycles, never while paused.
    always @(posedge clk_in) begin
        #2;
        bus.mem_valid = 1'b0;
        if (!rst_in || !bus.mem_req) begin
            lat_cnt = 0;
        end else if (!hold_mem && rdy_in) begin
            if (lat_cnt >= mem_lat) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = mem_word(bus.mem_addr);
                lat_cnt       = 0;
                if (rand_lat) mem_lat = $urandom_range(0, 3);
            end else begin
                lat_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        repeat (2) tick();
        check_val("rst_ready", {31'd0, bus.instruction_ready}, 32'd0);
        check_val("rst_req", {31'd0, bus.mem_req}, 32'd0);
        check_val("rst_addr", bus.mem_addr, 32'h0);
        check_val("rst_pc", bus.pc_out, 32'h0);
        push_cnt = 0;
        push_cyc_q.delete();
        push_pc_q.delete();
        push_pred_q.delete();
        miss_q.delete();
        rst_in = 1'b1;
    endtask

    task automatic run_pushes(input int n, input int budget);
        int t;
        t = 0;
        while (push_cnt < n && t < budget) begin
            tick();
            t++;
        end
        if (push_cnt < n) check_val("push_timeout", push_cnt, n);
    endtask

    task automatic wait_req(input int budget);
        int t;
        t = 0;
        while (!bus.mem_req && t < budget) begin
            tick();
            t++;
        end
        if (!bus.mem_req) check_val("req_timeout", {31'd0, bus.mem_req}, 32'd1);
    endtask

    task automatic load_loop();
        for (int i = 0; i < 256; i++) prog[i] = 32'h00000013;
        prog[4] = enc_b(-16);
    endtask

    initial begin
        logic [31:0] saved_pc, saved_addr;
        int          cnt0, zeros;
        bus.isq_is_full = 1'b0;
        for (int i = 0; i < 256; i++) prog[i] = 32'h00000013;

        // Cold start
        rdy_in = 1'b1;
        do_reset();
        run_pushes(4, 200);
        for (int i = 0; i < 4; i++) begin
            check_val("cold_miss_addr", (miss_q.size() > i) ? miss_q[i] : 32'hDEAD, 32'(i * 4));
            check_val("cold_push_pc", (push_pc_q.size() > i) ? push_pc_q[i] : 32'hDEAD, 32'(i * 4));
        end

        // Warm loop with backward BEQ at 0x10
        load_loop();
        do_reset();
        run_pushes(11, 300);
        check_val("loop_br_pc", push_pc_q[4], 32'h10);
        check_val("loop_br_pred", {31'd0, push_pred_q[4]}, 32'd1);
        check_val("loop_wrap_pc", push_pc_q[5], 32'h0);
        for (int i = 5; i < 11; i++) check_val("loop_rate", push_cyc_q[i] - push_cyc_q[i-1], 32'd1);

        // JAL +0x100 at 0
        for (int i = 0; i < 256; i++) prog[i] = 32'h00000013;
        prog[0] = enc_j(32'h100);
        do_reset();
        run_pushes(2, 200);
        check_val("jal_pred", {31'd0, push_pred_q[0]}, 32'd1);
        check_val("jal_target", push_pc_q[1], 32'h100);

        // Queue full for 3 cycles on a hit
        load_loop();
        do_reset();
        run_pushes(7, 300);
        saved_pc = bus.pc_out;
        cnt0 = push_cnt;
        bus.isq_is_full = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val("full_ready", {31'd0, bus.instruction_ready}, 32'd0);
            check_val("full_pc", bus.pc_out, saved_pc);
            if (i < 2) tick();
        end
        tick();
        bus.isq_is_full = 1'b0;
        #1;
        check_val("release_ready", {31'd0, bus.instruction_ready}, 32'd1);
        check_val("release_pc", bus.pc_out, saved_pc);
        tick();
        check_val("release_one_push", push_cnt, cnt0 + 1);
        check_val("release_next_pc", bus.pc_out, saved_pc + 32'd4);

        // roll_back two cycles into a miss, fill lands at cycle 5
        for (int i = 0; i < 256; i++) prog[i] = 32'h00000013;
        mem_lat = 4;
        do_reset();
        wait_req(20);
        tick();
        tick();
        roll_back = 1'b1;
        rollback_pc = 32'h40;
        tick();
        roll_back = 1'b0;
        tick();
        #2;
        check_val("abort_req_c5", {31'd0, bus.mem_req}, 32'd1);
        check_val("abort_valid_c5", {31'd0, bus.mem_valid}, 32'd1);
        check_val("abort_addr_c5", bus.mem_addr, 32'h0);
        mem_lat = 0;
        run_pushes(1, 100);
        check_val("abort_first_push", push_pc_q[0], 32'h40);
        roll_back = 1'b1;
        rollback_pc = 32'h0;
        tick();
        roll_back = 1'b0;
        cnt0 = push_cnt;
        while (push_cnt == cnt0 || push_pc_q[push_pc_q.size()-1] != 32'h0) begin
            if (push_cnt > cnt0 + 8) break;
            tick();
        end
        zeros = 0;
        foreach (miss_q[i]) if (miss_q[i] == 32'h0) zeros++;
        check_val("old_line_cached", zeros, 32'd1);

        // Async reset mid-miss, then pause for 4 cycles during a miss
        load_loop();
        do_reset();
        wait_req(20);
        hold_mem = 1'b1;
        rst_in = 1'b0;
        #1;
        check_val("rst_mid_miss_req", {31'd0, bus.mem_req}, 32'd0);
        do_reset();
        wait_req(20);
        saved_addr = bus.mem_addr;
        rdy_in = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_val("pause_req", {31'd0, bus.mem_req}, 32'd1);
            check_val("pause_addr", bus.mem_addr, saved_addr);
            check_val("pause_ready", {31'd0, bus.instruction_ready}, 32'd0);
            check_val("pause_pc", bus.pc_out, 32'h0);
            tick();
        end
        rdy_in = 1'b1;
        hold_mem = 1'b0;
        run_pushes(7, 300);

        // Randomized run over a mixed program
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 9))
                5, 6:    prog[i] = enc_b(-4 * int'($urandom_range(1, 8)));
                7:       prog[i] = enc_b(4 * int'($urandom_range(1, 8)));
                8:       prog[i] = enc_j(4 * (int'($urandom_range(0, 32)) - 16));
                9:       prog[i] = $urandom;
                default: prog[i] = 32'h00000013 | ($urandom & 32'hFFFFF000);
            endcase
        end
        rand_lat = 1'b1;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rdy_in          = ($urandom_range(0, 9) != 0);
            bus.isq_is_full = ($urandom_range(0, 4) == 0);
            roll_back       = ($urandom_range(0, 24) == 0);
            rollback_pc     = 32'($urandom_range(0, 255)) << 2;
            tick();
        end
        roll_back = 1'b0;
        if (push_cnt < 200) check_val("rand_progress", push_cnt, 32'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
